// File: rtl/eth_pkg.sv
// Shared Ethernet constants, status bit layout and RX framer state encoding.
package eth_pkg;

  localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
  localparam logic [7:0]  ETH_SFD         = 8'hD5;
  localparam logic [31:0] ETH_CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] ETH_CRC_RESIDUE = 32'hDEBB20E3;

  // Frame status vector {too_long, too_short, rx_er, fcs_bad}
  localparam int unsigned ST_FCS_BAD   = 0;
  localparam int unsigned ST_RX_ER     = 1;
  localparam int unsigned ST_TOO_SHORT = 2;
  localparam int unsigned ST_TOO_LONG  = 3;
  localparam int unsigned ST_W         = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_DATA  = 3'd2,
    S_FLUSH = 3'd3,
    S_DROP  = 3'd4
  } rx_state_e;

endpackage

// File: rtl/eth_crc32_d8.sv
// Combinational CRC-32 (reflected 0xEDB88320) advance by one byte, LSB first.
module eth_crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data_in,
  output logic [31:0] crc_out
);

  logic [31:0] c;

  // Bit-serial shift unrolled over the eight data bits
  always_comb begin
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data_in[i]) begin
        c = (c >> 1) ^ ETH_CRC_POLY;
      end else begin
        c = c >> 1;
      end
    end
    crc_out = c;
  end

endmodule

// File: rtl/gmii_rx_framer.sv
// GMII receive framer: strips preamble/SFD, checks FCS, length and rx_er,
// and streams frame bytes with sof/eof/status plus good/bad frame counters.
// Build option GMII_RX_FCS_STRIP_EN removes the 4 FCS bytes from the stream.
module gmii_rx_framer
  import eth_pkg::*;
#(
  parameter int unsigned MIN_FRAME = 64,
  parameter int unsigned MAX_FRAME = 1518,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             gmii_rx_clk,
  input  logic             reset,
  input  logic [7:0]       gmii_rxd,
  input  logic             gmii_rx_dv,
  input  logic             gmii_rx_er,
  output logic [7:0]       out_data,
  output logic             out_valid,
  output logic             out_sof,
  output logic             out_eof,
  output logic [ST_W-1:0]  out_status,
  output logic [CNT_W-1:0] frame_ok_cnt,
  output logic [CNT_W-1:0] frame_err_cnt
);

  localparam int unsigned DL_DEPTH = 5;
  localparam int unsigned FILL_W   = $clog2(DL_DEPTH + 1);
  localparam int unsigned LEN_W    = $clog2(MAX_FRAME + 2);
`ifdef GMII_RX_FCS_STRIP_EN
  localparam int unsigned RUNT_MAX = 4;
`else
  localparam int unsigned RUNT_MAX = 5;
`endif

  localparam logic [LEN_W-1:0]  LEN_SAT  = LEN_W'(MAX_FRAME + 1);
  localparam logic [LEN_W-1:0]  LEN_MAX  = LEN_W'(MAX_FRAME);
  localparam logic [LEN_W-1:0]  LEN_MIN  = LEN_W'(MIN_FRAME);
  localparam logic [LEN_W-1:0]  LEN_RUNT = LEN_W'(RUNT_MAX);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DL_DEPTH);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  rx_state_e                   state;
  logic [DL_DEPTH-1:0][7:0]    dl;
  logic [FILL_W-1:0]           fill;
  logic [31:0]                 crc;
  logic [31:0]                 crc_nxt;
  logic [LEN_W-1:0]            len;
  logic                        rx_er_acc;
  logic                        sof_pend;
  logic                        ok_pend;
  logic                        err_pend;
  logic [ST_W-1:0]             fin_status;
`ifndef GMII_RX_FCS_STRIP_EN
  logic [ST_W-1:0]             status_q;
  logic [2:0]                  flush_cnt;
`endif

  eth_crc32_d8 u_crc (
    .crc_in  (crc),
    .data_in (gmii_rxd),
    .crc_out (crc_nxt)
  );

  // Frame verdict from the accumulated state, used on the cycle dv falls
  always_comb begin
    fin_status               = '0;
    fin_status[ST_TOO_LONG]  = (len > LEN_MAX);
    fin_status[ST_TOO_SHORT] = (len < LEN_MIN);
    fin_status[ST_RX_ER]     = rx_er_acc;
    fin_status[ST_FCS_BAD]   = (crc != ETH_CRC_RESIDUE);
  end

  // Framer FSM, delay line, CRC/length accumulation, output beats and counters
  always_ff @(posedge gmii_rx_clk) begin
    if (reset) begin
      state         <= S_IDLE;
      dl            <= '0;
      fill          <= '0;
      crc           <= '1;
      len           <= '0;
      rx_er_acc     <= 1'b0;
      sof_pend      <= 1'b0;
      ok_pend       <= 1'b0;
      err_pend      <= 1'b0;
      out_data      <= '0;
      out_valid     <= 1'b0;
      out_sof       <= 1'b0;
      out_eof       <= 1'b0;
      out_status    <= '0;
      frame_ok_cnt  <= '0;
      frame_err_cnt <= '0;
`ifndef GMII_RX_FCS_STRIP_EN
      status_q      <= '0;
      flush_cnt     <= '0;
`endif
    end else begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_sof    <= 1'b0;
      out_eof    <= 1'b0;
      out_status <= '0;
      ok_pend    <= 1'b0;
      err_pend   <= 1'b0;

      if (ok_pend && (frame_ok_cnt != CNT_MAX)) begin
        frame_ok_cnt <= frame_ok_cnt + 1'b1;
      end
      if (err_pend && (frame_err_cnt != CNT_MAX)) begin
        frame_err_cnt <= frame_err_cnt + 1'b1;
      end

      // Frame accumulators are primed while waiting so DATA starts clean
      if ((state == S_IDLE) || (state == S_PRE)) begin
        fill      <= '0;
        crc       <= '1;
        len       <= '0;
        rx_er_acc <= 1'b0;
        sof_pend  <= 1'b1;
      end

      unique case (state)
        S_IDLE: begin
          if (gmii_rx_dv) begin
            if (gmii_rxd == ETH_PREAMBLE) begin
              state <= S_PRE;
            end else if (gmii_rxd == ETH_SFD) begin
              state <= S_DATA;
            end else begin
              state <= S_DROP;
            end
          end
        end

        S_PRE: begin
          if (!gmii_rx_dv) begin
            state <= S_IDLE;
          end else if (gmii_rx_er) begin
            state <= S_DROP;
          end else if (gmii_rxd == ETH_SFD) begin
            state <= S_DATA;
          end else if (gmii_rxd != ETH_PREAMBLE) begin
            state <= S_DROP;
          end
        end

        S_DATA: begin
          if (gmii_rx_dv) begin
            dl        <= {dl[DL_DEPTH-2:0], gmii_rxd};
            crc       <= crc_nxt;
            rx_er_acc <= rx_er_acc | gmii_rx_er;
            if (len != LEN_SAT) begin
              len <= len + 1'b1;
            end
            if (fill == FILL_FULL) begin
              out_valid <= 1'b1;
              out_data  <= dl[DL_DEPTH-1];
              out_sof   <= sof_pend;
              sof_pend  <= 1'b0;
            end else begin
              fill <= fill + 1'b1;
            end
          end else if (len <= LEN_RUNT) begin
            // Runt: nothing was or will be emitted, only the error count moves
            err_pend <= 1'b1;
            state    <= S_IDLE;
          end else begin
            out_valid <= 1'b1;
            out_data  <= dl[DL_DEPTH-1];
            out_sof   <= sof_pend;
            sof_pend  <= 1'b0;
`ifdef GMII_RX_FCS_STRIP_EN
            // Oldest entry is the last payload byte; the 4 FCS bytes are dropped
            out_eof    <= 1'b1;
            out_status <= fin_status;
            ok_pend    <= (fin_status == '0);
            err_pend   <= (fin_status != '0);
            state      <= S_IDLE;
`else
            status_q  <= fin_status;
            dl        <= {dl[DL_DEPTH-2:0], 8'h00};
            flush_cnt <= 3'(DL_DEPTH - 1);
            state     <= S_FLUSH;
`endif
          end
        end

`ifndef GMII_RX_FCS_STRIP_EN
        S_FLUSH: begin
          out_valid <= 1'b1;
          out_data  <= dl[DL_DEPTH-1];
          out_sof   <= sof_pend;
          sof_pend  <= 1'b0;
          dl        <= {dl[DL_DEPTH-2:0], 8'h00};
          flush_cnt <= flush_cnt - 1'b1;
          if (flush_cnt == 3'd1) begin
            out_eof    <= 1'b1;
            out_status <= status_q;
            ok_pend    <= (status_q == '0);
            err_pend   <= (status_q != '0);
            state      <= gmii_rx_dv ? S_DROP : S_IDLE;
          end
        end
`endif

        S_DROP: begin
          if (!gmii_rx_dv) begin
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gmii_rx_framer.sv
// Directed bench for gmii_rx_framer with an expected-beat scoreboard.
module tb_gmii_rx_framer;

  // Narrow counters so saturation is reachable in a short run
  localparam int unsigned TB_CNT_W = 3;
`ifdef GMII_RX_FCS_STRIP_EN
  localparam bit STRIP    = 1'b1;
  localparam int RUNT_MAX = 4;
`else
  localparam bit STRIP    = 1'b0;
  localparam int RUNT_MAX = 5;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic       sof;
    logic       eof;
    logic [3:0] status;
  } beat_t;

  logic                gmii_rx_clk;
  logic                reset;
  logic [7:0]          gmii_rxd;
  logic                gmii_rx_dv;
  logic                gmii_rx_er;
  logic [7:0]          out_data;
  logic                out_valid;
  logic                out_sof;
  logic                out_eof;
  logic [3:0]          out_status;
  logic [TB_CNT_W-1:0] frame_ok_cnt;
  logic [TB_CNT_W-1:0] frame_err_cnt;

  int checks = 0;
  int errors = 0;
  beat_t exp_q[$];
  logic [7:0] frm[$];
  logic [TB_CNT_W-1:0] exp_ok  = '0;
  logic [TB_CNT_W-1:0] exp_err = '0;

  gmii_rx_framer #(
    .MIN_FRAME (64),
    .MAX_FRAME (1518),
    .CNT_W     (TB_CNT_W)
  ) dut (
    .gmii_rx_clk   (gmii_rx_clk),
    .reset         (reset),
    .gmii_rxd      (gmii_rxd),
    .gmii_rx_dv    (gmii_rx_dv),
    .gmii_rx_er    (gmii_rx_er),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_sof       (out_sof),
    .out_eof       (out_eof),
    .out_status    (out_status),
    .frame_ok_cnt  (frame_ok_cnt),
    .frame_err_cnt (frame_err_cnt)
  );

  initial gmii_rx_clk = 1'b0;
  always #5 gmii_rx_clk = ~gmii_rx_clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // Every output beat must match the head of the scoreboard
  beat_t mon_e, mon_o;
  always @(negedge gmii_rx_clk) begin
    if (out_valid) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_beat observed data=%h sof=%b eof=%b expected none",
               out_data, out_sof, out_eof);
      end
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        mon_o = '{data: out_data, sof: out_sof, eof: out_eof,
                  status: (out_eof ? out_status : 4'h0)};
        assert (mon_o === mon_e) else begin
          errors++;
          $error("FAIL beat observed=%h expected=%h", mon_o, mon_e);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic dv, input logic er, input logic [7:0] d);
    @(negedge gmii_rx_clk);
    gmii_rx_dv = dv;
    gmii_rx_er = er;
    gmii_rxd   = d;
  endtask

  function automatic logic [31:0] crc_of(input logic [7:0] q[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (q[k]) begin
      for (int b = 0; b < 8; b++) begin
        if (c[0] ^ q[k][b]) c = (c >> 1) ^ 32'hEDB88320;
        else                c = c >> 1;
      end
    end
    return c;
  endfunction

  // Payload 0,1,2,... plus a correct FCS (complemented CRC, LSB byte first)
  task automatic build_good(input int n);
    logic [31:0] fcs;
    frm.delete();
    for (int i = 0; i < n; i++) frm.push_back(8'(i));
    fcs = ~crc_of(frm);
    for (int i = 0; i < 4; i++) frm.push_back(fcs[8*i +: 8]);
  endtask

  task automatic expect_frame(input logic [3:0] st);
    int n;
    int n_out;
    beat_t b;
    n     = frm.size();
    n_out = STRIP ? n - 4 : n;
    if (n > RUNT_MAX) begin
      for (int i = 0; i < n_out; i++) begin
        b.data   = frm[i];
        b.sof    = (i == 0);
        b.eof    = (i == n_out - 1);
        b.status = (i == n_out - 1) ? st : 4'h0;
        exp_q.push_back(b);
      end
    end
    if (st == 4'h0) begin
      if (exp_ok != '1) exp_ok = exp_ok + 1'b1;
    end else begin
      if (exp_err != '1) exp_err = exp_err + 1'b1;
    end
  endtask

  task automatic drive_frame(input int er_idx);
    for (int i = 0; i < 7; i++) put(1'b1, 1'b0, 8'h55);
    put(1'b1, 1'b0, 8'hD5);
    foreach (frm[i]) put(1'b1, (i == er_idx), frm[i]);
    put(1'b0, 1'b0, 8'h00);
  endtask

  task automatic drive_raw(input logic [7:0] q[$]);
    foreach (q[i]) put(1'b1, 1'b0, q[i]);
    put(1'b0, 1'b0, 8'h00);
  endtask

  // Idle gap long enough for flush and counter update, then check counters
  task automatic settle(input string tag);
    repeat (12) @(negedge gmii_rx_clk);
    chk({tag, "_ok_cnt"},  32'(frame_ok_cnt),  32'(exp_ok));
    chk({tag, "_err_cnt"}, 32'(frame_err_cnt), 32'(exp_err));
    chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [7:0] q[$];
    beat_t b;
    reset      = 1'b1;
    gmii_rxd   = 8'h00;
    gmii_rx_dv = 1'b0;
    gmii_rx_er = 1'b0;
    repeat (3) @(negedge gmii_rx_clk);
    reset = 1'b0;
    @(negedge gmii_rx_clk);
    chk("rst_valid",  32'(out_valid),     32'd0);
    chk("rst_sof",    32'(out_sof),       32'd0);
    chk("rst_eof",    32'(out_eof),       32'd0);
    chk("rst_data",   32'(out_data),      32'd0);
    chk("rst_status", 32'(out_status),    32'd0);
    chk("rst_ok",     32'(frame_ok_cnt),  32'd0);
    chk("rst_err",    32'(frame_err_cnt), 32'd0);

    // Good minimum-size frame
    build_good(60);
    expect_frame(4'b0000);
    drive_frame(-1);
    settle("good64");

    // "123456789" with its known FCS: too short only
    frm = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
           8'h26, 8'h39, 8'hF4, 8'hCB};
    expect_frame(4'b0100);
    drive_frame(-1);
    settle("check9");

    // One payload bit flipped: FCS bad
    build_good(60);
    frm[10] = frm[10] ^ 8'h04;
    expect_frame(4'b0001);
    drive_frame(-1);
    settle("bitflip");

    // rx_er pulsed mid-frame
    build_good(60);
    expect_frame(4'b0010);
    drive_frame(20);
    settle("rx_er");

    // 1600-byte frame: too long, every byte still streamed
    build_good(1596);
    expect_frame(4'b1000);
    drive_frame(-1);
    settle("long1600");

    // Broken preamble is dropped, a following good frame is received
    q = {8'h55, 8'h55, 8'h5A, 8'hD5};
    for (int i = 0; i < 20; i++) q.push_back(8'(i));
    drive_raw(q);
    settle("badpre");
    build_good(60);
    expect_frame(4'b0000);
    drive_frame(-1);
    settle("after_badpre");

    // rx_er during preamble drops the frame
    put(1'b1, 1'b0, 8'h55);
    put(1'b1, 1'b1, 8'h55);
    put(1'b1, 1'b0, 8'h55);
    put(1'b1, 1'b0, 8'hD5);
    for (int i = 0; i < 30; i++) put(1'b1, 1'b0, 8'(i));
    put(1'b0, 1'b0, 8'h00);
    settle("pre_er");

    // Runts of 5, 3 and 1 bytes; the error counter reaches saturation
    frm = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    expect_frame(4'b0101);
    drive_frame(-1);
    settle("runt5");
    frm = {8'h01, 8'h02, 8'h03};
    expect_frame(4'b0101);
    drive_frame(-1);
    settle("runt3");
    for (int r = 0; r < 2; r++) begin
      frm = {8'h07};
      expect_frame(4'b0101);
      drive_frame(-1);
      settle("runt1");
    end

    // Reset pulse in the middle of a frame
    for (int i = 0; i < 7; i++) put(1'b1, 1'b0, 8'h55);
    put(1'b1, 1'b0, 8'hD5);
    for (int i = 0; i < 15; i++) begin
      b = '{data: 8'(i), sof: (i == 0), eof: 1'b0, status: 4'h0};
      exp_q.push_back(b);
    end
    for (int i = 0; i < 20; i++) put(1'b1, 1'b0, 8'(i));
    put(1'b1, 1'b0, 8'd20);
    reset = 1'b1;
    @(negedge gmii_rx_clk);
    exp_ok  = '0;
    exp_err = '0;
    chk("mrst_valid",  32'(out_valid),     32'd0);
    chk("mrst_sof",    32'(out_sof),       32'd0);
    chk("mrst_eof",    32'(out_eof),       32'd0);
    chk("mrst_data",   32'(out_data),      32'd0);
    chk("mrst_status", 32'(out_status),    32'd0);
    chk("mrst_ok",     32'(frame_ok_cnt),  32'd0);
    chk("mrst_err",    32'(frame_err_cnt), 32'd0);
    chk("mrst_sb",     32'(exp_q.size()),  32'd0);
    reset = 1'b0;
    for (int i = 21; i < 41; i++) put(1'b1, 1'b0, 8'(i));
    put(1'b0, 1'b0, 8'h00);
    settle("after_mrst");

    build_good(60);
    expect_frame(4'b0000);
    drive_frame(-1);
    settle("final_good");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
